// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit loadable shift/rotate register with
// synchronous reset/set and a multi-cycle burst-shift engine.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
  localparam int unsigned AW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [AW-1:0] W_MAX = AW'(WIDTH);
  localparam logic [AW-1:0] W_ONE = AW'(1);

  state_t          r_state;
  logic [WIDTH-1:0] r_q;
  logic [AW-1:0]   r_cnt;
  logic            r_dir;
  logic            r_busy;
  logic            r_done;

  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_op_q;
  logic [WIDTH-1:0] w_burst_q;
  logic [AW-1:0]    w_amt_clamp;
  logic             w_burst_req;

  assign w_shr = {sin_r, r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], sin_l};
  assign w_ror = {r_q[0], r_q[WIDTH-1:1]};
  assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};

  // Burst direction latched at accept: 1 = left, 0 = right.
  assign w_burst_q = r_dir ? w_shl : w_shr;

  assign w_burst_req = mode[2] & mode[1];
  assign w_amt_clamp = (amt > W_MAX) ? W_MAX : amt;

  // Next q for the single-cycle modes issued from IDLE.
  always_comb begin
    w_op_q = r_q;
    case (mode)
      3'b001:  w_op_q = w_shr;
      3'b010:  w_op_q = w_shl;
      3'b011:  w_op_q = w_ror;
      3'b100:  w_op_q = w_rol;
      3'b101:  w_op_q = d;
      default: w_op_q = r_q;
    endcase
  end

  // Register bank and burst FSM; reset beats set beats mode operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= RESET_VAL;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (set) begin
      r_q     <= SET_VAL;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            if (w_burst_req) begin
              r_dir <= mode[0];
              r_cnt <= w_amt_clamp;
              if (w_amt_clamp == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_BURST;
                r_busy  <= 1'b1;
              end
            end else begin
              r_q <= w_op_q;
            end
          end
        end
        S_BURST: begin
          if (en) begin
            r_q   <= w_burst_q;
            r_cnt <= r_cnt - W_ONE;
            if (r_cnt == W_ONE) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q      = r_q;
  assign qbar   = ~r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed checks of univ_shift_reg (WIDTH=8)
// with immediate assertions at each comparison point.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk;
  logic          reset;
  logic          set;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin_r;
  logic          sin_l;
  logic [AW-1:0] amt;
  logic [W-1:0]  q;
  logic [W-1:0]  qbar;
  logic          sout_r;
  logic          sout_l;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .set(set), .en(en),
    .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .amt(amt), .q(q), .qbar(qbar), .sout_r(sout_r),
    .sout_l(sout_l), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = 3'b101; d = v;
    tick();
    mode = 3'b000;
  endtask

  initial begin
    reset = 1'b1; set = 1'b1; en = 1'b1; mode = 3'b101;
    d = 8'hA5; sin_r = 1'b0; sin_l = 1'b0; amt = '0;
    tick();
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", qbar, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_soutr", sout_r, 0);
    chk("rst_soutl", sout_l, 0);

    reset = 1'b0; mode = 3'b000;
    tick();
    chk("set_q", q, 8'hFF);
    set = 1'b0;

    en = 1'b0; mode = 3'b101; d = 8'h11;
    tick();
    chk("en0_hold", q, 8'hFF);

    load(8'hA5);
    chk("load_q", q, 8'hA5);
    chk("load_qbar", qbar, 8'h5A);
    mode = 3'b001; sin_r = 1'b1;
    tick();
    chk("shr_q", q, 8'hD2);
    mode = 3'b010; sin_l = 1'b0;
    tick();
    chk("shl_q", q, 8'hA4);
    mode = 3'b000;
    tick();
    chk("hold_q", q, 8'hA4);

    load(8'h81);
    mode = 3'b011;
    tick();
    chk("ror_q", q, 8'hC0);
    chk("ror_soutr", sout_r, 0);
    chk("ror_soutl", sout_l, 1);
    mode = 3'b100;
    tick();
    chk("rol1_q", q, 8'h81);
    tick();
    chk("rol2_q", q, 8'h03);
    chk("rol_soutr", sout_r, 1);
    chk("rol_soutl", sout_l, 0);

    load(8'hF0);
    mode = 3'b111; amt = 4'd3; sin_l = 1'b1;
    tick();
    chk("b3_acc_q", q, 8'hF0);
    chk("b3_acc_busy", busy, 1);
    chk("b3_acc_done", done, 0);
    mode = 3'b101; d = 8'h00; amt = 4'd9;
    tick();
    chk("b3_e1_q", q, 8'hE1);
    chk("b3_e1_busy", busy, 1);
    tick();
    chk("b3_e2_q", q, 8'hC3);
    chk("b3_e2_busy", busy, 1);
    mode = 3'b000;
    tick();
    chk("b3_e3_q", q, 8'h87);
    chk("b3_e3_busy", busy, 0);
    chk("b3_e3_done", done, 1);
    tick();
    chk("b3_done_clr", done, 0);
    chk("b3_hold_q", q, 8'h87);

    load(8'hA5);
    mode = 3'b110; amt = 4'd15; sin_r = 1'b0;
    tick();
    chk("b15_acc_busy", busy, 1);
    mode = 3'b000;
    for (int i = 0; i < 7; i++) tick();
    chk("b15_e7_q", q, 8'h01);
    chk("b15_e7_busy", busy, 1);
    chk("b15_e7_done", done, 0);
    tick();
    chk("b15_e8_q", q, 8'h00);
    chk("b15_e8_busy", busy, 0);
    chk("b15_e8_done", done, 1);

    load(8'h5A);
    mode = 3'b111; amt = 4'd0;
    tick();
    chk("b0_q", q, 8'h5A);
    chk("b0_busy", busy, 0);
    chk("b0_done", done, 1);
    mode = 3'b000;
    tick();
    chk("b0_done_clr", done, 0);

    load(8'hFF);
    mode = 3'b110; amt = 4'd4; sin_r = 1'b0;
    tick();
    mode = 3'b000;
    tick();
    chk("bp_e1_q", q, 8'h7F);
    tick();
    chk("bp_e2_q", q, 8'h3F);
    en = 1'b0;
    tick();
    chk("bp_p1_q", q, 8'h3F);
    chk("bp_p1_busy", busy, 1);
    tick();
    chk("bp_p2_q", q, 8'h3F);
    chk("bp_p2_busy", busy, 1);
    chk("bp_p2_done", done, 0);
    en = 1'b1;
    tick();
    chk("bp_e3_q", q, 8'h1F);
    chk("bp_e3_done", done, 0);
    tick();
    chk("bp_e4_q", q, 8'h0F);
    chk("bp_e4_busy", busy, 0);
    chk("bp_e4_done", done, 1);

    load(8'h0F);
    mode = 3'b111; amt = 4'd5; sin_l = 1'b0;
    tick();
    mode = 3'b000;
    tick();
    chk("ab_s_e1_q", q, 8'h1E);
    set = 1'b1;
    tick();
    set = 1'b0;
    chk("ab_s_q", q, 8'hFF);
    chk("ab_s_busy", busy, 0);
    chk("ab_s_done", done, 0);
    tick();
    chk("ab_s_nodone", done, 0);
    chk("ab_s_idle_q", q, 8'hFF);

    load(8'h0F);
    mode = 3'b111; amt = 4'd5;
    tick();
    mode = 3'b000;
    tick();
    chk("ab_r_e1_q", q, 8'h1E);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_r_q", q, 8'h00);
    chk("ab_r_busy", busy, 0);
    chk("ab_r_done", done, 0);
    tick();
    chk("ab_r_nodone", done, 0);
    chk("ab_r_idle_q", q, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with synchronous reset/set, complementary outputs, and eight operating modes (hold, shift, rotate, parallel load, multi-cycle burst shift). Sits wherever the design needs a loadable, shiftable state register, such as serialisers, LFSR seeds or staged control words. The burst-shift modes add a busy/done handshake and a small two-state FSM.

## Interface
- WIDTH, 8: register width in bits; must be ≥2.
- RESET_VAL, {WIDTH{1'b0}}: value loaded by `reset`.
- SET_VAL, {WIDTH{1'b1}}: value loaded by `set`.
- AW (localparam), $clog2(WIDTH)+1: width of `amt`.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- set  input  1  synchronous, active-high; loads SET_VAL; below `reset` in priority.
- en  input  1  clock enable for mode operations and burst progress.
- mode  input  3  000 hold, 001 shift right, 010 shift left, 011 rotate right, 100 rotate left, 101 parallel load, 110 burst shift right, 111 burst shift left.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input for right shifts (enters at the MSB).
- sin_l  input  1  serial input for left shifts (enters at the LSB).
- amt  input  AW  burst length in bit positions; values above WIDTH are clamped to WIDTH.
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  ~q (combinational).
- sout_r  output  1  q[0] (combinational).
- sout_l  output  1  q[WIDTH-1] (combinational).
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse when a burst completes.

## Operation
- Per-edge priority:
  1. `reset`: q=RESET_VAL, FSM=IDLE, cnt=0, busy=0, done=0.
  2. `set`: q=SET_VAL, FSM=IDLE, busy=0, done=0. This aborts any active burst, and no `done` pulse is issued.
  3. Otherwise, FSM behaviour below.
- Reset values: q=RESET_VAL, qbar=~RESET_VAL, busy=0, done=0, sout_r/sout_l taken from RESET_VAL.
- IDLE state, en=0: hold; done=0.
- IDLE state, en=1, single-cycle modes (next value of q):
  - 000: q (hold).
  - 001: {sin_r, q[WIDTH-1:1]}.
  - 010: {q[WIDTH-2:0], sin_l}.
  - 011: {q[0], q[WIDTH-1:1]}.
  - 100: {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101: d.
- IDLE state, en=1, mode 11x (accept edge):
  - Latch the direction (mode[0]) and cnt=min(amt, WIDTH).
  - If cnt≠0: go to BURST and set busy=1. q is unchanged on the accept edge.
  - If amt=0: stay in IDLE, done=1 for one cycle, q unchanged.
- BURST state:
  - Each edge with en=1: shift one position in the latched direction, using the live `sin_r`/`sin_l`; cnt decrements.
  - On the edge where cnt goes 1→0: go to IDLE, busy=0, done=1.
  - en=0: pause with q, cnt and busy held.
  - `mode`, `d` and `amt` are ignored while busy=1.
- done is cleared on every edge on which it is not being asserted.

## Timing
- Single-cycle modes: q is updated at the first rising edge where en=1. qbar, sout_r and sout_l follow q in the same cycle.
- Burst of k (1≤k≤WIDTH), en held high:
  - Accept at edge E0; shifts at E1..Ek.
  - busy is high from after E0 until Ek.
  - done is high for exactly the cycle after Ek.
  - Total latency from accept to done is k+1 edges.
- A new command may be accepted on the edge after busy falls, which is the same cycle in which done is high.
- Burst of 0: done is high in the cycle after E0; busy never rises.
- Reset or set asserted during a burst takes effect at the next edge. busy drops with that edge, and no done is issued.

## Test plan
- Reset with WIDTH=8: assert reset with set=1 and mode=101, d=8'hA5 -> q=8'h00, qbar=8'hFF, busy=0, done=0. Then set alone -> q=8'hFF.
- Load and shift: load 8'hA5, then one cycle of 001 with sin_r=1 -> q=8'hD2. Then one cycle of 010 with sin_l=0 -> q=8'hA4.
- Rotate: from 8'h81, mode 011 -> q=8'hC0. Then mode 100 twice -> q=8'h03. sout_r and sout_l must track q[0] and q[7].
- Burst: from 8'hF0, mode 111 with amt=3 and sin_l=1 -> busy high for 3 cycles, q=8'h87, done pulses once. With amt=15 -> clamped to 8, 8 shift cycles. With amt=0 -> immediate done, q unchanged.
- Burst pause: during a right burst with amt=4 from 8'hFF and sin_r=0, hold en=0 for 2 cycles mid-burst -> q and busy held. Burst resumes, final q=8'h0F, and done arrives 2 cycles later than without the pause.
- Abort: assert set during a burst -> q=8'hFF next edge, busy=0, no done. Repeat with reset -> q=RESET_VAL, no done.
